seq_mul_add: RTL and testbench



---
 rtl/seq_mul_add_pkg.sv | 16 +
 rtl/seq_mul_add.sv | 135 +++++++++++++
 tb/tb_seq_mul_add.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mul_add_pkg.sv
// Shared types for the sequential signed multiply-add: FSM state encoding
// and counter width helper.
package seq_mul_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int m);
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/seq_mul_add.sv
// Radix-2 shift-add signed multiply-add, result = A*B + C in 2M bits, valid/ready on both sides.
// Optional registered M-bit range overflow flag under MULADD_OVF_FLAG_EN.
module seq_mul_add
    import seq_mul_add_pkg::*;
#(
    parameter int M = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     multiplicand,
    input  logic [M-1:0]     multiplier,
    input  logic [M-1:0]     addend,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MULADD_OVF_FLAG_EN
    output logic             overflow,
`endif
    output logic [2*M-1:0]   result
);

    localparam int CW = cnt_width(M);

    // Magnitude of the most negative value is 2^(M-1), which still fits unsigned.
    function automatic logic [M-1:0] mag(input logic [M-1:0] v);
        return v[M-1] ? -v : v;
    endfunction

    function automatic logic [2*M-1:0] fix_result(input logic [2*M-1:0] acc,
                                                  input logic           neg,
                                                  input logic [2*M-1:0] c_ext);
        return (neg ? -acc : acc) + c_ext;
    endfunction

    state_t            r_state;
    state_t            w_next;
    logic [2*M-1:0]    r_mcand;
    logic [M-1:0]      r_mplier;
    logic              r_neg;
    logic [2*M-1:0]    r_addend;
    logic [2*M-1:0]    r_acc;
    logic [CW-1:0]     r_cnt;
    logic [2*M-1:0]    r_result;
    logic              r_out_valid;
    logic [2*M-1:0]    w_fix;

    assign w_fix     = fix_result(r_acc, r_neg, r_addend);
    assign result    = r_result;
    assign out_valid = r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = CALC;
            end
            CALC:    if (r_cnt == CW'(M - 1)) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The multiplicand magnitude shifts left one place per step, equivalent to shifting by the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_neg       <= 1'b0;
            r_addend    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{M{1'b0}}, mag(multiplicand)};
                        r_mplier <= mag(multiplier);
                        r_neg    <= multiplicand[M-1] ^ multiplier[M-1];
                        r_addend <= {{M{addend[M-1]}}, addend};
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_result    <= w_fix;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef MULADD_OVF_FLAG_EN
    logic r_ovf;
    logic [M:0] w_top;

    // In range for M-bit signed iff the upper M+1 bits are all sign copies.
    assign w_top    = w_fix[2*M-1:M-1];
    assign overflow = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == FIX) begin
            r_ovf <= ~((&w_top) | (~|w_top));
        end else if (r_state == DONE && out_ready) begin
            r_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_seq_mul_add.sv
// Scoreboard bench for seq_mul_add: directed and random M=8 cases plus an M=32 divider round-trip.
module tb_seq_mul_add;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- M = 8 instance ----------------
    logic        rst8_n = 1'b0;
    logic        iv8 = 1'b0;
    logic        ir8;
    logic        ov8;
    logic        ordy8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0, c8 = '0;
    logic [15:0] res8;
    logic [16:0] q8[$];
    logic [16:0] e8;
`ifdef MULADD_OVF_FLAG_EN
    logic        ovf8;
`endif

    seq_mul_add #(.M(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst8_n),
        .in_valid     (iv8),
        .in_ready     (ir8),
        .multiplicand (a8),
        .multiplier   (b8),
        .addend       (c8),
        .out_valid    (ov8),
        .out_ready    (ordy8),
`ifdef MULADD_OVF_FLAG_EN
        .overflow     (ovf8),
`endif
        .result       (res8)
    );

    function automatic logic [16:0] model8(input int a, input int b, input int c);
        int   p  = a * b + c;
        logic ov = (p < -128) || (p > 127);
        return {ov, p[15:0]};
    endfunction

    task automatic send8(input int a, input int b, input int c);
        int n = 0;
        @(negedge clk);
        a8  = a[7:0];
        b8  = b[7:0];
        c8  = c[7:0];
        iv8 = 1'b1;
        q8.push_back(model8(a, b, c));
        while (!ir8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept8", ir8, 1);
        @(posedge clk);
        #1 iv8 = 1'b0;
    endtask

    task automatic wait8();
        int n = 0;
        while (q8.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain8", q8.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst8_n && ov8 && ordy8) begin
            if (q8.size() == 0) begin
                chk("spurious8", ov8, 0);
            end else begin
                e8 = q8.pop_front();
                chk("res8", res8, e8[15:0]);
`ifdef MULADD_OVF_FLAG_EN
                chk("ovf8", ovf8, e8[16]);
`endif
            end
        end
    end

    task automatic run8();
        int          n;
        bit          ir_hi;
        bit          stable;
        logic [15:0] r0;
        int          tbl [5][3] = '{'{0, -5, -7}, '{127, 127, 127}, '{-128, 127, -128},
                                    '{-1, -1, -1}, '{1, -128, 127}};
        #12;
        chk("rst_in_ready", ir8, 1);
        chk("rst_out_valid", ov8, 0);
        chk("rst_result", res8, 0);
`ifdef MULADD_OVF_FLAG_EN
        chk("rst_overflow", ovf8, 0);
`endif
        @(negedge clk) rst8_n = 1'b1;

        send8(7, -3, 5);
        n = 0;
        ir_hi = 1'b0;
        while (!ov8 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (ir8) ir_hi = 1'b1;
        end
        chk("latency", n, 9);
        chk("busy_in_ready", ir_hi, 0);
        wait8();

        send8(-128, -128, 0);
        send8(3, 4, -20);
        wait8();

        foreach (tbl[i]) send8(tbl[i][0], tbl[i][1], tbl[i][2]);
        for (int i = 0; i < 40; i++)
            send8(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128);
        wait8();

        ordy8 = 1'b0;
        send8(5, 6, 1);
        n = 0;
        while (!ov8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", ov8, 1);
        r0 = res8;
        stable = 1'b1;
        ir_hi = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!ov8 || res8 !== r0) stable = 1'b0;
            if (ir8) ir_hi = 1'b1;
        end
        chk("bp_stable", stable, 1);
        chk("bp_in_ready", ir_hi, 0);
        chk("bp_result", r0, 16'd31);
        @(posedge clk);
        #1 ordy8 = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("bp_release_valid", ov8, 0);
        chk("bp_release_ready", ir8, 1);

        send8(9, 9, 0);
        repeat (3) @(posedge clk);
        #2 rst8_n = 1'b0;
        #1;
        chk("arst_out_valid", ov8, 0);
        chk("arst_result", res8, 0);
        chk("arst_in_ready", ir8, 1);
        q8.delete();
        @(negedge clk) rst8_n = 1'b1;
        send8(2, 2, 0);
        wait8();

        send8(11, -13, 100);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            c8  = 8'($urandom);
            iv8 = i[0];
        end
        @(negedge clk) iv8 = 1'b0;
        wait8();
        repeat (4) @(negedge clk);
        chk("no_extra_op", ov8, 0);
    endtask

    // ---------------- M = 32 instance ----------------
    logic        rst32_n = 1'b0;
    logic        iv32 = 1'b0;
    logic        ir32;
    logic        ov32;
    logic        ordy32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0, c32 = '0;
    logic [63:0] res32;
    logic [63:0] q32[$];
    logic [63:0] e32;
`ifdef MULADD_OVF_FLAG_EN
    logic        ovf32;
`endif

    seq_mul_add #(.M(32)) u_dut32 (
        .clk          (clk),
        .rst_n        (rst32_n),
        .in_valid     (iv32),
        .in_ready     (ir32),
        .multiplicand (a32),
        .multiplier   (b32),
        .addend       (c32),
        .out_valid    (ov32),
        .out_ready    (ordy32),
`ifdef MULADD_OVF_FLAG_EN
        .overflow     (ovf32),
`endif
        .result       (res32)
    );

    initial begin
        forever begin
            @(posedge clk);
            #1 ordy32 = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (rst32_n && ov32 && ordy32) begin
            if (q32.size() == 0) begin
                chk("spurious32", ov32, 0);
            end else begin
                e32 = q32.pop_front();
                chk("res32", res32, e32);
`ifdef MULADD_OVF_FLAG_EN
                chk("ovf32", ovf32, 0);
`endif
            end
        end
    end

    task automatic send32(input int a, input int b, input int c, input int dividend);
        int n = 0;
        @(negedge clk);
        a32  = a;
        b32  = b;
        c32  = c;
        iv32 = 1'b1;
        q32.push_back({{32{dividend[31]}}, dividend});
        while (!ir32 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept32", ir32, 1);
        @(posedge clk);
        #1 iv32 = 1'b0;
    endtask

    task automatic run32();
        int dd, dv, n;
        #12;
        chk("rst32_result", res32, 0);
        chk("rst32_in_ready", ir32, 1);
        @(negedge clk) rst32_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            dd = int'($urandom) >>> $urandom_range(0, 31);
            do begin
                dv = int'($urandom) >>> $urandom_range(0, 31);
            end while (dv == 0 || (dd == int'(32'h8000_0000) && dv == -1));
            send32(dd / dv, dv, dd % dv, dd);
        end
        n = 0;
        while (q32.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain32", q32.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            run8();
            run32();
        join
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
